// File: rtl/reg_dump_reader_if.sv
// Register-file read port and outgoing byte stream of the register dump engine.
// The engine drives the master side; the register set and the stream sink form the slave side.
interface reg_dump_reader_if #(
    parameter int DataWidth = 8,
    parameter int SEL_WIDTH = 2
);
    logic                 rd_en;
    logic [SEL_WIDTH-1:0] rd_sel;
    logic [DataWidth-1:0] rd_data;
    logic [DataWidth-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output rd_en, rd_sel, out_data, out_valid,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_sel, out_data, out_valid,
        output rd_data, out_ready
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register file read port 0..NUM_REGISTERS-1 and streams each value out as one byte.
// Define REG_DUMP_CHECKSUM_EN to append a trailing modulo-2^DataWidth checksum byte.
module reg_dump_reader #(
    parameter int DataWidth     = 8,
    parameter int SEL_WIDTH     = 2,
    parameter int NUM_REGISTERS = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    output logic              busy,
    output logic              done,
    reg_dump_reader_if.master bus
);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGISTERS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
`endif

    state_t               state;
    state_t               state_next;
    logic [SEL_WIDTH-1:0] index;
    logic [DataWidth-1:0] out_data_q;
    logic                 xfer;
    logic                 last;

    assign xfer = bus.out_valid && bus.out_ready;
    assign last = (index == LAST_IDX);

    // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case, so no branch can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = READ;
            READ: state_next = SEND;
            SEND: begin
                if (xfer) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    state_next = last ? CSUM : READ;
`else
                    state_next = last ? DONE : READ;
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: if (xfer) state_next = DONE;
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DataWidth-1:0] acc;

    // The accumulator sees exactly the bytes captured in READ, so it matches the stream.
    always_ff @(posedge clk) begin
        if (res) begin
            acc <= '0;
        end else if (state == IDLE && start) begin
            acc <= '0;
        end else if (state == READ) begin
            acc <= acc + bus.rd_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            index      <= '0;
            out_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) index <= '0;
                READ: out_data_q <= bus.rd_data;
                SEND: begin
                    if (xfer && !last) begin
                        index <= index + 1'b1;
                    end
`ifdef REG_DUMP_CHECKSUM_EN
                    if (xfer && last) begin
                        out_data_q <= acc;
                    end
`endif
                end
                // Clearing here keeps rd_sel at 0 throughout IDLE.
                DONE:    index <= '0;
                default: ;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign bus.rd_en     = (state == READ);
    assign bus.rd_sel    = index;
    assign bus.out_data  = out_data_q;
`ifdef REG_DUMP_CHECKSUM_EN
    assign bus.out_valid = (state == SEND) || (state == CSUM);
`else
    assign bus.out_valid = (state == SEND);
`endif

endmodule
